// File: rtl/led_trail_pwm_pkg.sv
// Shared constants and helpers for the LED comet-tail display stage.
`timescale 1ns/1ps
package led_trail_pwm_pkg;

  typedef enum logic {
    CNT_DOWN = 1'b0,
    CNT_UP   = 1'b1
  } count_dir_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

  // Counters need at least one bit even when they only ever hold 0.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : clog2(n);
  endfunction

  function automatic int unsigned lmax(input int unsigned bits);
    return (32'd1 << bits) - 1;
  endfunction

endpackage

// File: rtl/led_trail_pwm_channel.sv
// One LED channel: intensity register (load/halve/hold) and PWM output flop.
`timescale 1ns/1ps
module trail_channel
  import led_trail_pwm_pkg::*;
#(
  parameter int unsigned PWM_BITS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led
);

  localparam logic [PWM_BITS-1:0] LEVEL_MAX = PWM_BITS'(lmax(PWM_BITS));

  logic [PWM_BITS-1:0] r_level;

  // Load wins over decay; the output compares against the pre-update level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_level <= '0;
      led     <= 1'b0;
    end else begin
      if (load)      r_level <= LEVEL_MAX;
      else if (tick) r_level <= r_level >> 1;
      led <= (r_level > pwm_cnt);
    end
  end

endmodule

// File: rtl/n_counter.sv
// Modulo-fin_cuenta up/down counter with a terminal-count strobe.
`timescale 1ns/1ps
module n_counter
  import led_trail_pwm_pkg::*;
#(
  parameter int unsigned fin_cuenta = 4,
  parameter int unsigned WIDTH      = cnt_width(fin_cuenta)
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic up_down,
  output logic TC
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(fin_cuenta - 1);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (enable) begin
      if (up_down) r_count <= (r_count == LAST) ? '0 : r_count + 1'b1;
      else         r_count <= (r_count == '0) ? LAST : r_count - 1'b1;
    end
  end

  // Gated by enable so a wrap coinciding with enable falling produces no strobe.
  assign TC = enable & (up_down ? (r_count == LAST) : (r_count == '0));

endmodule

// File: rtl/led_trail_pwm.sv
// LED display stage: lit position at full brightness, vacated LEDs fade geometrically.
`timescale 1ns/1ps
module led_trail_pwm
  import led_trail_pwm_pkg::*;
#(
  parameter int unsigned N_LEDS    = 8,
  parameter int unsigned PWM_BITS  = 4,
  parameter int unsigned DECAY_DIV = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [N_LEDS-1:0] leds_in,
  output logic [N_LEDS-1:0] leds_out,
  output logic              tick
);

  localparam int unsigned         PRESC_W  = cnt_width(DECAY_DIV);
  localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'(lmax(PWM_BITS) - 1);

  logic                w_tick_int;
  logic [N_LEDS-1:0]   w_load;
  logic [PWM_BITS-1:0] r_pwm_cnt;

  n_counter #(
    .fin_cuenta (DECAY_DIV),
    .WIDTH      (PRESC_W)
  ) u_presc (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .up_down (CNT_UP),
    .TC      (w_tick_int)
  );

  // Period is LMAX, not 2^PWM_BITS, so a full level really is constant on.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pwm_cnt <= '0;
      tick      <= 1'b0;
    end else begin
      r_pwm_cnt <= (r_pwm_cnt == PWM_LAST) ? '0 : r_pwm_cnt + 1'b1;
      tick      <= w_tick_int;
    end
  end

  assign w_load = leds_in & {N_LEDS{enable}};

  for (genvar g = 0; g < N_LEDS; g++) begin : g_ch
    trail_channel #(
      .PWM_BITS (PWM_BITS)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .load    (w_load[g]),
      .tick    (w_tick_int),
      .pwm_cnt (r_pwm_cnt),
      .led     (leds_out[g])
    );
  end

endmodule
